// File: rtl/wb_bram_burst.sv
`default_nettype none
// ============================================================================
// Module      : wb_bram_burst
// Description : Wishbone B4 registered-feedback slave around a single-port
//               block RAM with byte-lane writes and zero-wait read bursts
//               (linear / wrap4 / wrap8 / wrap16).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bram_burst #(
    parameter int DATA_W    = 32,
    parameter int MEM_ADR_W = 11,
    parameter int ADR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADR_W-1:0]      adr,
    input  logic [DATA_W-1:0]     dat_ms,
    output logic [DATA_W-1:0]     dat_sm,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   sel,
    input  logic                  stb,
    input  logic                  cyc,
    input  logic [2:0]            cti,
    input  logic [1:0]            bte,
    output logic                  ack
);

    localparam int       c_nb       = DATA_W / 8;
    localparam int       c_lsb      = $clog2(c_nb);
    localparam int       c_depth    = 2 ** MEM_ADR_W;
    localparam bit [2:0] c_cti_incr = 3'b010;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    logic [c_nb-1:0][7:0] mem [c_depth];

    state_t                r_state_q,  w_state_d;
    logic                  r_ack_r_q,  w_ack_r_d;
    logic [DATA_W-1:0]     r_dat_q,    w_dat_d;
    logic [MEM_ADR_W-1:0]  r_baddr_q,  w_baddr_d;

    logic                  w_req;
    logic                  w_wr_en;
    logic [MEM_ADR_W-1:0]  w_idx;
    logic                  w_unused_adr;

    assign w_req        = cyc & stb;
    assign w_wr_en      = ~rst & w_req & we;
    assign w_idx        = adr[MEM_ADR_W+c_lsb-1:c_lsb];
    assign w_unused_adr = ^adr;

    assign ack    = (w_req & we) | r_ack_r_q;
    assign dat_sm = r_dat_q;

    // Wrap modes only advance the low k bits; the mask keeps the upper bits.
    function automatic logic [MEM_ADR_W-1:0] f_next(
        input logic [MEM_ADR_W-1:0] a,
        input logic [1:0]           mode
    );
        logic [MEM_ADR_W-1:0] inc;
        logic [MEM_ADR_W-1:0] mask;
        inc = a + MEM_ADR_W'(1);
        case (mode)
            2'b01:   mask = MEM_ADR_W'(3);
            2'b10:   mask = MEM_ADR_W'(7);
            2'b11:   mask = MEM_ADR_W'(15);
            default: mask = '1;
        endcase
        return (a & ~mask) | (inc & mask);
    endfunction

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < c_nb; i++) begin
                if (sel[i]) begin
                    mem[w_idx][i] <= dat_ms[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_ack_r_d = r_ack_r_q;
        w_dat_d   = r_dat_q;
        w_baddr_d = r_baddr_q;
        case (r_state_q)
            ST_IDLE: begin
                // A classic read ack is held for one cycle only, so the
                // master's still-asserted stb does not start a second read.
                if (r_ack_r_q) begin
                    w_ack_r_d = 1'b0;
                end else if (w_req && !we) begin
                    w_dat_d   = mem[w_idx];
                    w_ack_r_d = 1'b1;
                    if (cti == c_cti_incr) begin
                        w_state_d = ST_BURST;
                        w_baddr_d = f_next(w_idx, bte);
                    end
                end
            end
            ST_BURST: begin
                if (w_req && !we && cti == c_cti_incr) begin
                    w_dat_d   = mem[r_baddr_q];
                    w_baddr_d = f_next(r_baddr_q, bte);
                    w_ack_r_d = 1'b1;
                end else begin
                    w_state_d = ST_IDLE;
                    w_ack_r_d = 1'b0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_ack_r_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_ack_r_q <= 1'b0;
            r_dat_q   <= '0;
            r_baddr_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_ack_r_q <= w_ack_r_d;
            r_dat_q   <= w_dat_d;
            r_baddr_q <= w_baddr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_bram_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bram_burst
// Description : Directed bench for wb_bram_burst (32-bit default and a
//               64-bit / 16-word instance) with a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bram_burst;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] adr, dat_ms, dat_sm;
    logic        we, stb, cyc, ack;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;

    logic [31:0] b_adr;
    logic [63:0] b_dat_ms, b_dat_sm;
    logic        b_we, b_stb, b_cyc, b_ack;
    logic [7:0]  b_sel;
    logic [2:0]  b_cti;
    logic [1:0]  b_bte;

    wb_bram_burst dut (
        .clk(clk), .rst(rst), .adr(adr), .dat_ms(dat_ms), .dat_sm(dat_sm),
        .we(we), .sel(sel), .stb(stb), .cyc(cyc), .cti(cti), .bte(bte), .ack(ack)
    );

    wb_bram_burst #(.DATA_W(64), .MEM_ADR_W(4), .ADR_W(32)) dut64 (
        .clk(clk), .rst(rst), .adr(b_adr), .dat_ms(b_dat_ms), .dat_sm(b_dat_sm),
        .we(b_we), .sel(b_sel), .stb(b_stb), .cyc(b_cyc), .cti(b_cti), .bte(b_bte),
        .ack(b_ack)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb [$];
    logic [31:0] mdl [0:2047];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        e = (sb.size() != 0) ? sb.pop_front() : 64'hx;
        chk(tag, obs, e);
    endtask

    function automatic int nxt(input int w, input logic [1:0] mode, input int depth);
        int k, span, base;
        k = (mode == 2'b00) ? 0 : int'(mode) + 1;
        if (k == 0) return (w + 1) % depth;
        span = 1 << k;
        base = w - (w % span);
        return base + ((w + 1) % span);
    endfunction

    task automatic idle_a();
        cyc = 0; stb = 0; we = 0; sel = 0; cti = 0; bte = 0; adr = 0; dat_ms = 0;
    endtask

    task automatic idle_b();
        b_cyc = 0; b_stb = 0; b_we = 0; b_sel = 0; b_cti = 0; b_bte = 0;
        b_adr = 0; b_dat_ms = 0;
    endtask

    task automatic wr_a(input int word, input logic [31:0] data, input logic [3:0] s);
        adr = 32'(word * 4); dat_ms = data; sel = s;
        cyc = 1; stb = 1; we = 1; cti = 3'b000;
        #1 chk("wr_ack", ack, 64'd1);
        for (int i = 0; i < 4; i++)
            if (s[i]) mdl[word][i*8 +: 8] = data[i*8 +: 8];
        step();
        idle_a();
    endtask

    task automatic rd_a(input int word);
        sb.push_back({32'h0, mdl[word]});
        adr = 32'(word * 4); cyc = 1; stb = 1; we = 0; cti = 3'b000;
        #1 chk("rd_wait", ack, 64'd0);
        step();
        chk("rd_ack", ack, 64'd1);
        chk_pop("rd_data", {32'h0, dat_sm});
        step();
        idle_a();
        #1 chk("rd_ack_low", ack, 64'd0);
    endtask

    task automatic burst_a(input int start, input logic [1:0] mode, input int n, input string tag);
        int w;
        w = start;
        for (int i = 0; i < n; i++) begin
            sb.push_back({32'h0, mdl[w]});
            w = nxt(w, mode, 2048);
        end
        adr = 32'(start * 4); cyc = 1; stb = 1; we = 0; cti = 3'b010; bte = mode;
        #1 chk({tag, "_wait"}, ack, 64'd0);
        step();
        for (int i = 0; i < n; i++) begin
            cti = (i == n - 1) ? 3'b111 : 3'b010;
            #1 chk({tag, "_ack"}, ack, 64'd1);
            chk_pop({tag, "_data"}, {32'h0, dat_sm});
            step();
        end
        idle_a();
        #1 chk({tag, "_end"}, ack, 64'd0);
    endtask

    initial begin
        rst = 1;
        idle_a();
        idle_b();
        step();
        step();
        rst = 0;
        #1 chk("rst_ack", ack, 64'd0);
        chk("rst_dat", {32'h0, dat_sm}, 64'd0);
        chk("rst_ack64", b_ack, 64'd0);

        // Full-word write then classic read
        wr_a(4, 32'hDEADBEEF, 4'hF);
        rd_a(4);

        // Byte lanes
        wr_a(4, 32'h0000_0000, 4'hF);
        wr_a(4, 32'hAABBCCDD, 4'b0101);
        rd_a(4);
        chk("sel0101_model", {32'h0, mdl[4]}, 64'h0000_0000_00BB_00DD);
        wr_a(4, 32'hFFFF_FFFF, 4'b0000);
        rd_a(4);

        // Bursts
        for (int i = 0; i < 8; i++) wr_a(i, 32'(i * 32'h11), 4'hF);
        burst_a(2, 2'b00, 4, "lin");
        burst_a(6, 2'b01, 4, "wrap4");
        burst_a(6, 2'b10, 4, "wrap8");
        wr_a(2047, 32'hCAFEF00D, 4'hF);
        burst_a(2047, 2'b00, 2, "lin_top");

        // Abort by dropping stb after two beats
        sb.push_back({32'h0, mdl[0]});
        sb.push_back({32'h0, mdl[1]});
        adr = 32'h0; cyc = 1; stb = 1; we = 0; cti = 3'b010; bte = 2'b00;
        #1 chk("abort_wait", ack, 64'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            #1 chk("abort_beat_ack", ack, 64'd1);
            chk_pop("abort_beat_data", {32'h0, dat_sm});
            step();
        end
        stb = 0;
        step();
        #1 chk("abort_ack", ack, 64'd0);
        idle_a();

        // Reset mid-burst
        sb.push_back({32'h0, mdl[3]});
        adr = 32'(3 * 4); cyc = 1; stb = 1; we = 0; cti = 3'b010; bte = 2'b00;
        #1 chk("rstb_wait", ack, 64'd0);
        step();
        #1 chk("rstb_ack", ack, 64'd1);
        chk_pop("rstb_data", {32'h0, dat_sm});
        rst = 1;
        step();
        rst = 0;
        idle_a();
        #1 chk("rstb_ack_low", ack, 64'd0);
        chk("rstb_dat_clr", {32'h0, dat_sm}, 64'd0);
        rd_a(5);

        // 64-bit instance: byte adr 0x08 is word 1, upper-half lane write
        b_adr = 32'h08; b_cyc = 1; b_stb = 1; b_we = 1; b_sel = 8'hFF;
        b_dat_ms = 64'h1111_2222_3333_4444;
        #1 chk("b_wr_ack", b_ack, 64'd1);
        step();
        b_sel = 8'hF0; b_dat_ms = 64'hAAAA_AAAA_BBBB_BBBB;
        #1 chk("b_wr_hi_ack", b_ack, 64'd1);
        step();
        b_adr = 32'h78; b_sel = 8'hFF; b_dat_ms = 64'hF0F0_F0F0_0F0F_0F0F;
        step();
        b_adr = 32'h00; b_dat_ms = 64'h0123_4567_89AB_CDEF;
        step();
        sb.push_back(64'hAAAA_AAAA_3333_4444);
        b_adr = 32'h08; b_we = 0; b_sel = 8'h00; b_cti = 3'b000;
        #1 chk("b_rd_wait", b_ack, 64'd0);
        step();
        chk("b_rd_ack", b_ack, 64'd1);
        chk_pop("b_rd_data", b_dat_sm);
        step();
        idle_b();
        #1 chk("b_rd_ack_low", b_ack, 64'd0);

        sb.push_back(64'hF0F0_F0F0_0F0F_0F0F);
        sb.push_back(64'h0123_4567_89AB_CDEF);
        b_adr = 32'h78; b_cyc = 1; b_stb = 1; b_we = 0; b_cti = 3'b010; b_bte = 2'b11;
        #1 chk("b_wrap16_wait", b_ack, 64'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            b_cti = (i == 1) ? 3'b111 : 3'b010;
            #1 chk("b_wrap16_ack", b_ack, 64'd1);
            chk_pop("b_wrap16_data", b_dat_sm);
            step();
        end
        idle_b();
        #1 chk("b_wrap16_end", b_ack, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_bram_burst.md
Name: wb_bram_burst

Overview:
- Parametrised Wishbone B4 registered-feedback slave wrapping a single-port block RAM.
- Next generation of the team's Wishbone BlockRAM: configurable data width and depth, arbitrary byte-lane writes, and zero-wait incrementing read bursts with linear/wrap4/wrap8/wrap16 addressing (BTE).
- Sits behind the interconnect as a scratch or frame-line buffer for the video/stream masters.

Parameters:
- DATA_W, 32, data bus width in bits; one of 32 or 64.
- MEM_ADR_W, 11, word-address width; depth = 2**MEM_ADR_W words.
- ADR_W, 32, Wishbone byte-address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- adr  in  ADR_W  byte address; word index = adr[MEM_ADR_W+LSB-1:LSB], LSB = log2(DATA_W/8).
- dat_ms  in  DATA_W  write data, master to slave.
- dat_sm  out  DATA_W  read data, slave to master, registered.
- we  in  1  1 = write, 0 = read.
- sel  in  DATA_W/8  byte-lane enables.
- stb  in  1  strobe.
- cyc  in  1  bus cycle valid; stb is ignored when cyc=0.
- cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; others treated as 000.
- bte  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- ack  out  1  transfer acknowledge.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, ack_r=0, dat_sm=0, burst_addr=0. Memory contents are not cleared. rst has priority over all other events.
- req = cyc & stb. Memory is never initialised.
- Writes:
  - ack = (req & we) | ack_r, combinational, zero wait state.
  - On the same edge, each byte lane i with sel[i]=1 is written; all 2**(DATA_W/8) sel patterns are legal. sel=0 acks with no memory change.
- States: IDLE and BURST.
- IDLE, read (req & ~we):
  - mem[word index of adr] is registered into dat_sm, and ack_r=1 on the next cycle (one wait state).
  - If cti=010: go to BURST, burst_addr <= next(index).
  - Otherwise: stay in IDLE. The following edge forces ack_r=0, so back-to-back classic reads take 2 cycles each. This avoids a double ack while the master still holds stb.
- BURST, read with req & ~we and cti=010:
  - Reads mem[burst_addr] into dat_sm, burst_addr <= next(burst_addr), ack_r stays 1.
  - Result: one beat per cycle after the first.
- BURST termination:
  - cti=111 in a cycle where ack=1: final beat, next state IDLE, ack_r=0.
  - cti=000, req=0 or cyc=0: abort, IDLE, ack_r=0.
  - req & we: terminate burst; the write proceeds as above.
- next(a), applied to the low k bits of a (k = 0, 2, 3, 4 for bte 00, 01, 10, 11):
  - Linear (k=0): a+1 modulo depth; the word after 2**MEM_ADR_W-1 is 0.
  - Wrap modes: low k bits incremented modulo 2**k, upper bits held.
- Internal burst_addr is authoritative; the master's adr is ignored after the first beat.
- Reset mid-burst: IDLE and ack=0 on the next cycle; no spurious beat.

Test Plan:
- Reset, then write 0xDEADBEEF to byte adr 0x10 with sel=1111 -> ack high the same cycle; classic read of 0x10 -> ack at cycle+1 with dat_sm=0xDEADBEEF, ack low the cycle after.
- Preload word 4 = 0x00000000, write sel=0101 data 0xAABBCCDD -> readback 0x00BB00DD; sel=0000 -> unchanged.
- Words 0..7 = i*0x11; linear burst from word 2, beats cti=010,010,010,111 -> acks on 4 consecutive cycles after one wait, data 0x22, 0x33, 0x44, 0x55; ack low the next cycle.
- Wrap4 burst from word 6, 4 beats -> data words 6, 7, 4, 5; wrap8 from word 6 -> 6, 7, 0, 1. Linear burst from word 2047 (MEM_ADR_W=11) -> 2047, 0.
- Drop stb mid-burst after 2 beats, then rst pulse during a new burst -> ack=0 the next cycle each time; a fresh classic read afterwards returns correct data with one wait state.
- DATA_W=64, MEM_ADR_W=4: byte adr 0x08 maps to word 1; sel=0xF0 writes upper 32 bits only; burst wrap16 from word 15 -> 15, 0.
